// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : VGA raster timing generator. Divides clk by two to form the
//             pixel clock, runs the x/y raster counters on the falling edge
//             of that pixel clock, and produces registered sync, blanking
//             and line/frame start strobes aligned with the counters.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       vgaclk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // 10-bit versions of the boundaries so every compare is width-matched
  localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W     = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W     = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VIS + V_FP + V_SYNC);

  logic       p;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_n_next;
  logic       vsync_n_next;
  logic       blank_n_next;
  logic       line_start_next;
  logic       frame_start_next;

  // The pixel clock is the phase flop itself, so it is glitch-free.
  assign vgaclk = p;

  // Phase flop: toggles every clk edge; p==1 marks the next edge as an advance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= 1'b0;
    end else begin
      p <= ~p;
    end
  end

  // Next raster position and the decodes of that position, so the registered
  // outputs line up with x/y on the same advance edge.
  always_comb begin
    x_next = x;
    y_next = y;
    if (x == H_LAST) begin
      x_next = '0;
      y_next = (y == V_LAST) ? '0 : y + 10'd1;
    end else begin
      x_next = x + 10'd1;
    end
    blank_n_next     = (x_next < H_VIS_W) && (y_next < V_VIS_W);
    hsync_n_next     = !((x_next >= H_SYNC_BEG) && (x_next < H_SYNC_END));
    vsync_n_next     = !((y_next >= V_SYNC_BEG) && (y_next < V_SYNC_END));
    line_start_next  = (x_next == 10'd0);
    frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);
  end

  // Raster registers: reset parks the beam on the last pixel of the frame so
  // the first advance edge after release lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (p) begin
      x           <= x_next;
      y           <= y_next;
      hsync_n     <= hsync_n_next;
      vsync_n     <= vsync_n_next;
      blank_n     <= blank_n_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_VIS 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: hsync width
- H_BP 48: horizontal back porch
- V_VIS 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vsync width
- V_BP 33: vertical back porch

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- vgaclk  out  1  pixel clock to the DAC, clk/2
- x  out  10  horizontal pixel counter
- y  out  10  vertical line counter
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- blank_n  out  1  high inside the visible area
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 and y==0

REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

REQ-004 x and y SHALL feed the pixel-colour generator directly; that generator interprets them as screen coordinates while blank_n=1.

Function
REQ-005 H_TOT SHALL equal H_VIS+H_FP+H_SYNC+H_BP (800), and V_TOT SHALL equal V_VIS+V_FP+V_SYNC+V_BP (525).

REQ-006 Phase flop p SHALL toggle every clk rising edge; vgaclk SHALL equal p.

REQ-007 Advance edge: a clk edge where p==1 before the edge SHALL be an advance edge; all other outputs SHALL change only on advance edges, i.e. on vgaclk falling, and are stable at vgaclk rising.

REQ-008 Horizontal count: on each advance edge, x SHALL increment; x==H_TOT-1 SHALL wrap to 0.

REQ-009 Vertical count: y SHALL increment only on the advance edge where x wraps; y==V_TOT-1 with x wrap SHALL wrap to 0.

REQ-010 All outputs SHALL be registered and aligned to x/y, with zero latency; each decode SHALL be computed from the next-count value and take effect on the same edge.

REQ-011 blank_n SHALL be 1 iff x<H_VIS and y<V_VIS.

REQ-012 hsync_n SHALL be 0 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (656..751).

REQ-013 vsync_n SHALL be 0 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (490..491), independent of x.

REQ-014 line_start SHALL be 1 iff x==0; frame_start SHALL be 1 iff x==0 and y==0. Each pulse therefore lasts one pixel period (2 clk).

REQ-015 No output SHALL glitch between advance edges; x and y SHALL never exceed H_TOT-1 and V_TOT-1.

Reset
REQ-016 While rst_n=0, the outputs SHALL hold: p=0, vgaclk=0, x=H_TOT-1 (799), y=V_TOT-1 (524), hsync_n=1, vsync_n=1, blank_n=0, line_start=0, frame_start=0.

REQ-017 After rst_n deasserts, the first clk edge SHALL set p=1; the second edge is the first advance edge and SHALL move to x=0, y=0, blank_n=1, line_start=1, frame_start=1.

REQ-018 Assertion of rst_n mid-frame SHALL immediately force the REQ-016 values regardless of clk; no partial line SHALL complete.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Reset hold: rst_n=0, clk running -> x=799, y=524, blank_n=0, syncs=1, vgaclk=0 constantly.
- Release: deassert rst_n -> 2nd clk edge gives x=0, y=0, frame_start=1, blank_n=1; frame_start drops exactly 2 clk later (x=1).
- Line timing: count advance edges in line 0 -> blank_n=1 for 640, hsync_n=0 for exactly 96 starting at x=656, line length 800; y increments at x 799->0.
- Frame timing: run one full frame -> vsync_n=0 for y=490..491 (1600 pixels), blank_n=0 for all y>=480, frame_start once per 420000 pixels (840000 clk).
- Wrap: at x=799, y=524 -> next advance gives x=0, y=0, frame_start=1.
- Mid-frame reset: assert rst_n at x=300, y=200 between clk edges -> outputs take REQ-016 values asynchronously; after release, sequence restarts per REQ-017.
